led_sequencer: RTL and testbench
================================

// Module: led_sequencer
// PURPOSE
//   Drives the 8 green LEDs (LEDG) with a visible animated pattern.
//   Divides CLOCK_50 down to a human-visible step rate, then sequences the
//   LED register through a switch-selected mode: off, blink, chase or bounce.
//   Takes over the raw every-cycle LED toggling at top level. MODE/ENABLE
//   come from board switches, already synchronised upstream.
// PARAMETERS
//   TICK_DIV  12_500_000  CLOCK_50 cycles per pattern step (4 Hz); legal >= 1
//   N_LEDS    8           LED register width; fixed at 8 for LEDG
// PORTS
//   CLOCK_50  in   1  system clock, 50 MHz, all state on posedge
//   RESET     in   1  asynchronous, active-high reset
//   MODE      in   2  00 off, 01 blink, 10 chase, 11 bounce
//   ENABLE    in   1  1 = run, 0 = pause (freeze prescaler and LEDs)
//   LEDG      out  8  LED pattern, registered
//   TICK      out  1  one-cycle step strobe, registered (debug/test)
// BEHAVIOUR
//   Reset (async, immediate, no clock needed):
//     LEDG=0x00, TICK=0, prescaler cnt=0, state=S_OFF, mode_q=2'b00.
//   Prescaler: cnt counts 0..TICK_DIV-1 while ENABLE=1 and state!=S_OFF.
//     Step edge = edge where cnt==TICK_DIV-1 and counting: cnt<=0,
//     LEDG<=next pattern, TICK<=1. TICK=0 on every other edge.
//     Latency: LEDG changes on the step edge; TICK is high for the cycle
//     after it. TICK_DIV=1: cnt stays 0, step every cycle.
//   Mode load (highest priority below reset): on any edge where
//     MODE!=mode_q: mode_q<=MODE, cnt<=0, TICK<=0, load initial pattern.
//     Applies regardless of ENABLE. A coincident step is discarded.
//     Because mode_q resets to 00, a nonzero MODE at reset release
//     loads on the first edge.
//   States / initial load / step rule:
//     S_OFF       (00)  LEDG=0x00; cnt held at 0; no steps, TICK=0.
//     S_BLINK     (01)  load 0xFF; step: LEDG <= ~LEDG.
//     S_CHASE     (10)  load 0x01; step: rotate left, 0x80 -> 0x01.
//     S_BOUNCE_L  (11)  load 0x01; step: shift left; on reaching 0x80
//                       the same edge sets state=S_BOUNCE_R.
//     S_BOUNCE_R        step: shift right; on reaching 0x01 the same edge
//                       sets state=S_BOUNCE_L. Each end held exactly one
//                       step, never repeated.
//   ENABLE=0: cnt, LEDG, state frozen; TICK=0. On resume the step fires
//     after the remaining TICK_DIV-1-cnt cycles; the elapsed count is kept.
//   Width: cnt is $clog2(TICK_DIV) bits, min 1; compare only, no overflow.
//   LEDG is always one-hot in chase/bounce; never 0x00 outside S_OFF and
//     the blink off phase.
// STRUCTURE
//   Package led_seq_pkg: MODE_OFF/BLINK/CHASE/BOUNCE codes, state encoding
//     (S_OFF,S_BLINK,S_CHASE,S_BOUNCE_L,S_BOUNCE_R), PAT_ALL_ON=8'hFF,
//     PAT_FIRST=8'h01, PAT_LAST=8'h80.
//   Sub-module tick_prescaler #(TICK_DIV) (CLOCK_50, RESET, en, clr, tick):
//     counter plus terminal-count strobe. led_sequencer holds the FSM,
//     mode_q and the LEDG register.
// TESTING (bench uses TICK_DIV=4)
//   1 RESET pulsed between clock edges mid-chase -> LEDG=0x00, TICK=0
//     at once, before the next posedge.
//   2 MODE=01, ENABLE=1 -> LEDG=0xFF one edge after the change, then
//     0x00/0xFF alternate every 4 cycles; TICK high 1 of every 4 cycles.
//   3 MODE=10 -> 0x01,0x02,...,0x80,0x01 at 4-cycle spacing (wrap checked).
//   4 MODE=11 -> 0x01..0x80,0x40..0x01,0x02; 0x80 and 0x01 each appear
//     for exactly one step.
//   5 Chase at cnt=2, ENABLE=0 for 10 cycles -> LEDG/TICK unchanged;
//     after ENABLE=1 the next step comes exactly 2 cycles later.
//   6 MODE 10->01 on the step edge -> LEDG=0xFF (load wins), TICK=0,
//     next step exactly 4 cycles later; MODE->00 gives LEDG=0x00, no TICK.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// Shared mode codes, FSM state encoding and LED pattern constants for the
// LED sequencer slice.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_OFF,
    S_BLINK,
    S_CHASE,
    S_BOUNCE_L,
    S_BOUNCE_R
  } state_e;

  localparam logic [7:0] PAT_ALL_ON = 8'hFF;
  localparam logic [7:0] PAT_FIRST  = 8'h01;
  localparam logic [7:0] PAT_LAST   = 8'h80;

  // Entry state for a freshly selected mode; bounce always starts leftward.
  function automatic state_e mode_entry(input mode_e m);
    case (m)
      MODE_BLINK:  return S_BLINK;
      MODE_CHASE:  return S_CHASE;
      MODE_BOUNCE: return S_BOUNCE_L;
      default:     return S_OFF;
    endcase
  endfunction

  function automatic logic [7:0] mode_pattern(input mode_e m);
    case (m)
      MODE_BLINK:  return PAT_ALL_ON;
      MODE_CHASE,
      MODE_BOUNCE: return PAT_FIRST;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Switch inputs and LED/step outputs of the LED sequencer, bundled.
interface led_sequencer_if;
  logic [1:0] MODE;
  logic       ENABLE;
  logic [7:0] LEDG;
  logic       TICK;

  modport master (output MODE, ENABLE, input  LEDG, TICK);
  modport slave  (input  MODE, ENABLE, output LEDG, TICK);
endinterface

// File: rtl/led_sequencer_tick_prescaler.sv
// Free-running step prescaler: counts 0..TICK_DIV-1 while enabled and
// flags the terminal count combinationally so the caller registers it.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LEDG animator: prescaled step strobe drives an off/blink/chase/bounce
// pattern FSM selected by MODE, pausable by ENABLE.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned N_LEDS   = 8
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  led_sequencer_if.slave  bus
);

  state_e              state_q, state_d;
  mode_e               mode_q,  mode_d;
  logic [N_LEDS-1:0]   led_q,   led_d;
  logic                tick_q,  tick_d;
  logic                load;
  logic                step;
  logic                pre_en;
  logic                pre_clr;

  assign pre_en  = bus.ENABLE && (state_q != S_OFF);
  assign pre_clr = load || (state_q == S_OFF);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .en       (pre_en),
    .clr      (pre_clr),
    .tick     (step)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_OFF;
      mode_q  <= MODE_OFF;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  // A mode change outranks a coincident step: the step is simply dropped.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    load    = 1'b0;
    if (bus.MODE != mode_q) begin
      load    = 1'b1;
      mode_d  = mode_e'(bus.MODE);
      state_d = mode_entry(mode_e'(bus.MODE));
      led_d   = N_LEDS'(mode_pattern(mode_e'(bus.MODE)));
    end else if (step) begin
      tick_d = 1'b1;
      case (state_q)
        S_BLINK: led_d = ~led_q;
        S_CHASE: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
        S_BOUNCE_L: begin
          led_d = led_q << 1;
          if (led_d == N_LEDS'(PAT_LAST)) state_d = S_BOUNCE_R;
        end
        S_BOUNCE_R: begin
          led_d = led_q >> 1;
          if (led_d == N_LEDS'(PAT_FIRST)) state_d = S_BOUNCE_L;
        end
        default: led_d = '0;
      endcase
    end
  end

  assign bus.LEDG = 8'(led_q);
  assign bus.TICK = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer at TICK_DIV=4: vector table, directed corner
// sequences and randomized run against a step-index reference model.
module tb_led_sequencer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  led_sequencer_if bus();

  led_sequencer #(.TICK_DIV(TD), .N_LEDS(8)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: selected mode, prescaler count and step index.
  int         m_mode;
  int         m_cnt;
  int         m_pos;
  logic [7:0] m_led;
  logic       m_tick;

  function automatic logic [7:0] pat(input int m, input int p);
    logic [7:0] one;
    int q;
    one = 8'h01;
    case (m)
      1: return (p % 2 == 0) ? 8'hFF : 8'h00;
      2: return one << (p % 8);
      3: begin
        q = p % 14;
        return (q <= 7) ? (one << q) : (one << (14 - q));
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pos = 0; m_led = 8'h00; m_tick = 1'b0;
  endtask

  task automatic model_step(input int md, input logic en);
    m_tick = 1'b0;
    if (md != m_mode) begin
      m_mode = md; m_cnt = 0; m_pos = 0;
    end else if (m_mode != 0 && en) begin
      if (m_cnt == TD - 1) begin
        m_cnt = 0; m_pos++; m_tick = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    m_led = pat(m_mode, m_pos);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step(int'(bus.MODE), bus.ENABLE);
    @(posedge clk);
    #1;
    check("mdl_led", bus.LEDG, m_led);
    check("mdl_tick", {7'b0, bus.TICK}, {7'b0, m_tick});
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [7:0] led;
    logic       tick;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] bounce_exp [15];
  logic [7:0] hold;
  int waited;

  initial begin
    bus.MODE = 2'b00;
    bus.ENABLE = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_led", bus.LEDG, 8'h00);
    check("reset_tick", {7'b0, bus.TICK}, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Blink then chase, cycle by cycle from reset.
    vecs.push_back('{2'b00, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 8'hFF, 1'b0});
    repeat (3) vecs.push_back('{2'b01, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 8'h00, 1'b1});
    repeat (3) vecs.push_back('{2'b01, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{2'b01, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{2'b10, 1'b1, 8'h01, 1'b0});
    repeat (3) vecs.push_back('{2'b10, 1'b1, 8'h01, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{2'b00, 1'b1, 8'h00, 1'b0});
    repeat (5) vecs.push_back('{2'b00, 1'b1, 8'h00, 1'b0});
    foreach (vecs[i]) begin
      bus.MODE = vecs[i].mode;
      bus.ENABLE = vecs[i].en;
      cycle();
      check("tbl_led", bus.LEDG, vecs[i].led);
      check("tbl_tick", {7'b0, bus.TICK}, {7'b0, vecs[i].tick});
    end

    // Chase wraps 0x80 -> 0x01.
    bus.MODE = 2'b10;
    cycle();
    for (int s = 1; s <= 8; s++) begin
      repeat (TD) cycle();
      check("chase_step", bus.LEDG, (s == 8) ? 8'h01 : (8'h01 << s));
    end

    // Async reset between edges just after a step.
    waited = 0;
    while (!m_tick && waited < 2 * TD) begin cycle(); waited++; end
    check("pre_reset_tick", {7'b0, bus.TICK}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", bus.LEDG, 8'h00);
    check("async_rst_tick", {7'b0, bus.TICK}, 8'h00);
    model_reset();
    #3 rst = 1'b0;
    cycle();
    check("chase_reload", bus.LEDG, 8'h01);

    // Pause at cnt=2 for 10 cycles, then step exactly 2 cycles after resume.
    repeat (TD) cycle();
    waited = 0;
    while (m_cnt != 2 && waited < 2 * TD) begin cycle(); waited++; end
    hold = bus.LEDG;
    bus.ENABLE = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("pause_led", bus.LEDG, hold);
      check("pause_tick", {7'b0, bus.TICK}, 8'h00);
    end
    bus.ENABLE = 1'b1;
    cycle();
    check("resume1_tick", {7'b0, bus.TICK}, 8'h00);
    cycle();
    check("resume2_tick", {7'b0, bus.TICK}, 8'h01);
    check("resume2_led", bus.LEDG, {hold[6:0], hold[7]});

    // Mode change on the step edge: load wins, step dropped.
    waited = 0;
    while (m_cnt != TD - 1 && waited < 2 * TD) begin cycle(); waited++; end
    bus.MODE = 2'b01;
    cycle();
    check("load_wins_led", bus.LEDG, 8'hFF);
    check("load_wins_tick", {7'b0, bus.TICK}, 8'h00);
    repeat (TD - 1) begin
      cycle();
      check("after_load_tick", {7'b0, bus.TICK}, 8'h00);
    end
    cycle();
    check("after_load_step", {7'b0, bus.TICK}, 8'h01);
    check("after_load_led", bus.LEDG, 8'h00);
    bus.MODE = 2'b00;
    cycle();
    check("off_led", bus.LEDG, 8'h00);
    repeat (8) begin
      cycle();
      check("off_no_tick", {7'b0, bus.TICK}, 8'h00);
    end

    // Bounce: each end shown for exactly one step.
    for (int s = 0; s < 15; s++) begin
      int p;
      p = (s + 1) % 14;
      bounce_exp[s] = (p <= 7) ? (8'h01 << p) : (8'h01 << (14 - p));
    end
    bus.MODE = 2'b11;
    cycle();
    check("bounce_load", bus.LEDG, 8'h01);
    for (int s = 0; s < 15; s++) begin
      repeat (TD) cycle();
      check("bounce_step", bus.LEDG, bounce_exp[s]);
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) bus.MODE = 2'($urandom_range(0, 3));
      bus.ENABLE = ($urandom_range(0, 9) != 0);
      cycle();
      if (m_mode >= 2) begin
        n_cmp++;
        if (!$onehot(bus.LEDG)) begin
          n_fail++;
          $display("FAIL onehot: got 0x%02h expected one-hot at %0t", bus.LEDG, $time);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
